// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared op encodings, command width and host FSM states.
package spi_ram_pkg;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    localparam int CMD_W = 10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT,
        ST_CAPT,
        ST_GAP
    } state_t;
endpackage

// File: rtl/spi_host_shifter.sv
// spi_host_shifter: MSB-first parallel-load output shifter and MSB-first input shifter.
// Ports: load/shift_out drive the CMD_W-bit output register (sout = its MSB);
//        shift_in captures sin; word is the received byte with sin as its newest bit.
module spi_host_shifter
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_out,
    input  logic              shift_in,
    input  logic [CMD_W-1:0]  din,
    input  logic              sin,
    output logic              sout,
    output logic [DATA_W-1:0] word
);
    logic [CMD_W-1:0]  obuf;
    logic [DATA_W-2:0] ibuf;

    // Only DATA_W-1 bits are stored: the last bit is taken live from sin so the
    // full byte is available on the same edge that samples it.
    assign word = {ibuf, sin};
    assign sout = obuf[CMD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf <= '0;
            ibuf <= '0;
        end else begin
            if (load)
                obuf <= din;
            else if (shift_out)
                obuf <= {obuf[CMD_W-2:0], 1'b0};
            if (shift_in)
                ibuf <= word[DATA_W-2:0];
        end
    end
endmodule

// File: rtl/spi_ram_host.sv
// spi_ram_host: turns valid/ready RAM commands into SPI frames and captures read-data bytes.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_data command side; rd_valid/rd_data read result;
//        busy while a frame or gap runs; ss_n/mosi/miso SPI side clocked by clk.
module spi_ram_host
    import spi_ram_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);
    localparam int WW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            state, nxt;
    logic [3:0]        bcnt;
    logic [WW-1:0]     wcnt;
    logic [GW-1:0]     gcnt;
    logic              rd_op, load, shift_out, shift_in, sout, cap_last;
    logic [DATA_W-1:0] word;

    spi_host_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_out (shift_out),
        .shift_in  (shift_in),
        .din       ({cmd_op, cmd_data}),
        .sin       (miso),
        .sout      (sout),
        .word      (word)
    );

    assign busy     = (state != ST_IDLE);
    assign cap_last = (state == ST_CAPT) && (bcnt == 4'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bcnt     <= 4'd0;
            wcnt     <= '0;
            gcnt     <= '0;
            rd_op    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= nxt;
            // bcnt times SEL (0..1), SHIFT (0..9) and CAPT (0..7); cleared on every state change
            bcnt     <= (state == nxt && (state == ST_SEL || state == ST_SHIFT || state == ST_CAPT)) ? bcnt + 4'd1 : 4'd0;
            wcnt     <= (state == ST_WAIT && nxt == ST_WAIT) ? wcnt + WW'(1) : '0;
            gcnt     <= (state == ST_GAP && nxt == ST_GAP) ? gcnt + GW'(1) : '0;
            rd_valid <= cap_last;
            if (load)
                rd_op <= (cmd_op == OP_RD_DATA);
            if (cap_last)
                rd_data <= word;
        end
    end

    always_comb begin
        nxt       = state;
        load      = 1'b0;
        shift_out = 1'b0;
        shift_in  = 1'b0;
        ss_n      = 1'b1;
        mosi      = 1'b0;
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !rst;
                load      = cmd_valid && !rst;
                nxt       = load ? ST_SEL : ST_IDLE;
            end
            ST_SEL: begin
                // second SEL cycle already presents the read/write select bit
                ss_n = 1'b0;
                mosi = bcnt[0] & sout;
                nxt  = bcnt[0] ? ST_SHIFT : ST_SEL;
            end
            ST_SHIFT: begin
                ss_n      = 1'b0;
                mosi      = sout;
                shift_out = 1'b1;
                if (bcnt == 4'd9)
                    nxt = !rd_op ? ST_GAP : (RD_LAT == 0) ? ST_CAPT : ST_WAIT;
            end
            ST_WAIT: begin
                ss_n = 1'b0;
                nxt  = (wcnt == WW'(RD_LAT - 1)) ? ST_CAPT : ST_WAIT;
            end
            ST_CAPT: begin
                ss_n     = 1'b0;
                shift_in = 1'b1;
                nxt      = (bcnt == 4'd7) ? ST_GAP : ST_CAPT;
            end
            ST_GAP: nxt = (gcnt == GW'(GAP - 1)) ? ST_IDLE : ST_GAP;
            default: nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_ram_host.sv
// tb_spi_ram_host: randomized command stream checked cycle by cycle against a frame-level model.
module tb_spi_ram_host;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       miso = 1'b0;
    logic       cmd_ready, rd_valid, busy, ss_n, mosi;
    logic [7:0] rd_data;

    logic       z_cmd_valid = 1'b0;
    logic [1:0] z_cmd_op = 2'b00;
    logic [7:0] z_cmd_data = 8'h00;
    logic       z_miso = 1'b0;
    logic       z_cmd_ready, z_rd_valid, z_busy, z_ss_n, z_mosi;
    logic [7:0] z_rd_data;

    always #5 clk = ~clk;

    spi_ram_host #(.RD_LAT(L), .GAP(1), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    spi_ram_host #(.RD_LAT(0), .GAP(1), .DATA_W(8)) dut_z (
        .clk(clk), .rst(rst), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready),
        .cmd_op(z_cmd_op), .cmd_data(z_cmd_data), .rd_valid(z_rd_valid), .rd_data(z_rd_data),
        .busy(z_busy), .ss_n(z_ss_n), .mosi(z_mosi), .miso(z_miso)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // expected bus state for one cycle of a frame
    typedef struct packed {
        logic       ss;
        logic       mo;
        logic       rv;
        logic [7:0] rd;
    } ent_t;

    ent_t       q[$];
    bit         cur_idle = 1'b0;
    logic [7:0] m_rd = 8'h00;
    bit   [7:0] m_mem[256];
    logic [7:0] m_waddr = 8'h00, m_raddr = 8'h00;

    // model comparison: one queue entry per frame cycle, empty queue means idle
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            q.delete();
            cur_idle = 1'b0;
            m_rd = 8'h00;
        end else begin
            cur_idle = (q.size() == 0);
            e = '0;
            e.ss = 1'b1;
            if (!cur_idle) e = q.pop_front();
            if (e.rv) m_rd = e.rd;
            chk("ss_n", ss_n, e.ss);
            chk("mosi", mosi, e.mo);
            chk("rd_valid", rd_valid, e.rv);
            chk("rd_data", rd_data, m_rd);
            chk("busy", busy, !cur_idle);
            chk("cmd_ready", cmd_ready, cur_idle);
        end
    end

    // slave/RAM model decoding mosi and answering reads, plus frame-length monitor
    int         scnt = 0, hi_run = 0, last_hi = 0, last_lo = 0, rv_cnt = 0;
    logic [9:0] sh = '0;
    bit   [7:0] s_mem[256];
    logic [7:0] s_addr = 8'h00, s_raddr = 8'h00, s_out = 8'h00;
    bit         s_rd = 1'b0;
    logic       mlog[32];

    always @(negedge clk) begin
        if (rd_valid) rv_cnt++;
        if (!ss_n) begin
            if (hi_run > 0) begin
                last_hi = hi_run;
                hi_run = 0;
            end
            if (scnt < 32) mlog[scnt] = mosi;
            if (scnt >= 2 && scnt <= 11) sh = {sh[8:0], mosi};
            if (scnt == 11) begin
                case (sh[9:8])
                    2'b00:   s_addr = sh[7:0];
                    2'b01:   s_mem[s_addr] = sh[7:0];
                    2'b10:   s_raddr = sh[7:0];
                    default: begin
                        s_rd = 1'b1;
                        s_out = s_mem[s_raddr];
                    end
                endcase
            end
            miso = (s_rd && scnt >= 12 + L && scnt < 20 + L) ? s_out[19 + L - scnt] : 1'b0;
            scnt++;
        end else begin
            if (scnt > 0) last_lo = scnt;
            scnt = 0;
            s_rd = 1'b0;
            miso = 1'b0;
            hi_run++;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [1:0] op, input logic [7:0] d);
        logic [9:0] b;
        ent_t e;
        b = {op, d};
        e = '0;
        q.push_back(e);
        e.mo = op[1];
        q.push_back(e);
        for (int i = 9; i >= 0; i--) begin
            e.mo = b[i];
            q.push_back(e);
        end
        e.mo = 1'b0;
        if (op == 2'b11) repeat (L + 8) q.push_back(e);
        e.ss = 1'b1;
        e.rv = (op == 2'b11);
        e.rd = m_mem[m_raddr];
        q.push_back(e);
        case (op)
            2'b00:   m_waddr = d;
            2'b01:   m_mem[m_waddr] = d;
            2'b10:   m_raddr = d;
            default: ;
        endcase
    endtask

    // presents a command once the model says the host is idle; returns in frame cycle 0
    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit noise);
        int g = 0;
        while (!cur_idle && g < 300) begin
            if (noise) begin
                cmd_valid = 1'($urandom);
                cmd_op = 2'($urandom);
                cmd_data = 8'($urandom);
            end
            step();
            g++;
        end
        if (!cur_idle) begin
            checks++;
            errors++;
            $display("FAIL send timeout at %0t: got busy want idle", $time);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        push_frame(op, d);
        step();
    endtask

    task automatic wait_idle(input bit noise);
        int g = 0;
        if (!noise) cmd_valid = 1'b0;
        while (!cur_idle && g < 300) begin
            if (noise) begin
                cmd_valid = 1'($urandom);
                cmd_op = 2'($urandom);
                cmd_data = 8'($urandom);
            end
            step();
            g++;
        end
        cmd_valid = 1'b0;
        if (!cur_idle) begin
            checks++;
            errors++;
            $display("FAIL idle timeout at %0t: got busy want idle", $time);
        end
    endtask

    logic [10:0] got;
    logic [7:0]  pat = 8'h5A;
    int          rv0;

    initial begin
        #3;
        chk("reset ss_n", ss_n, 1);
        chk("reset mosi", mosi, 0);
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset busy", busy, 0);
        chk("reset z ss_n", z_ss_n, 1);
        step();
        rst = 1'b0;
        #1;
        chk("ready after reset", cmd_ready, 1);

        // write-addr 0x3C with garbage on the command inputs while it runs
        send(2'b00, 8'h3C, 1'b0);
        wait_idle(1'b1);
        got = '0;
        for (int i = 1; i <= 11; i++) got = {got[9:0], mlog[i]};
        chk("wr_addr mosi", got, 11'b00000111100);
        chk("wr_addr ss_n low", last_lo, 12);

        // write 0xA7 to 0x05 then read it back
        rv0 = rv_cnt;
        send(2'b00, 8'h05, 1'b0);
        send(2'b01, 8'hA7, 1'b0);
        send(2'b10, 8'h05, 1'b0);
        send(2'b11, 8'h00, 1'b0);
        wait_idle(1'b0);
        chk("readback data", rd_data, 8'hA7);
        chk("readback pulses", rv_cnt - rv0, 1);
        chk("readback ss_n low", last_lo, 12 + L + 8);

        // back-to-back with cmd_valid held
        send(2'b01, 8'h11, 1'b0);
        send(2'b01, 8'h22, 1'b0);
        wait_idle(1'b0);
        chk("b2b ss_n high", last_hi, 2);

        // reset during CAPT bit 4 of a read
        send(2'b11, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        repeat (12 + L + 4) step();
        rv0 = rv_cnt;
        rst = 1'b1;
        #1;
        chk("midrst ss_n", ss_n, 1);
        chk("midrst rd_data", rd_data, 0);
        chk("midrst rd_valid", rd_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst cmd_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst ready after", cmd_ready, 1);
        repeat (4) step();
        chk("midrst no pulse", rv_cnt - rv0, 0);

        // zero-latency read: miso 0x5A from cycle 12
        z_cmd_valid = 1'b1;
        z_cmd_op = 2'b11;
        z_cmd_data = 8'h00;
        #1;
        chk("z ready", z_cmd_ready, 1);
        step();
        z_cmd_valid = 1'b0;
        for (int c = 0; c < 22; c++) begin
            z_miso = (c >= 12 && c < 20) ? pat[19 - c] : 1'b0;
            #1;
            if (c == 0) chk("z ss_n c0", z_ss_n, 0);
            if (c == 19) begin
                chk("z ss_n c19", z_ss_n, 0);
                chk("z rd_valid c19", z_rd_valid, 0);
            end
            if (c == 20) begin
                chk("z rd_valid c20", z_rd_valid, 1);
                chk("z rd_data c20", z_rd_data, 8'h5A);
                chk("z ss_n c20", z_ss_n, 1);
            end
            if (c == 21) chk("z rd_valid c21", z_rd_valid, 0);
            step();
        end

        // randomized command stream
        for (int n = 0; n < 60; n++) begin
            send(2'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                wait_idle(1'b0);
                repeat ($urandom_range(0, 3)) step();
            end
        end
        wait_idle(1'b0);
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ram_host.md
Name: spi_ram_host

Overview:
- SPI host-side controller that sits directly upstream of the SPI-slave/RAM wrapper: it drives ss_n and mosi and samples miso.
- It turns single-command requests from a local requester (valid/ready) into complete SPI frames.
- The four RAM operations are write-address, write-data, read-address and read-data.
- For read-data frames it captures the 8-bit byte returned on miso and presents it on a one-cycle valid pulse.

Parameters:
- RD_LAT, 2: cycles between the last mosi bit of a read-data frame and the first miso sample.
- GAP, 1: minimum ss_n-high cycles between frames (must be at least 1).
- DATA_W, 8: RAM data/address byte width.

Ports:
- clk  input  1  system clock; it is also the SPI bit clock seen by the slave.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the host can accept a command this cycle.
- cmd_op  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  input  DATA_W  address/data byte; don't-care for op 11.
- rd_valid  output  1  one-cycle pulse: rd_data is valid.
- rd_data  output  DATA_W  byte captured from miso.
- busy  output  1  a frame is in progress, or the inter-frame gap is running.
- ss_n  output  1  slave select, active low.
- mosi  output  1  serial data to the slave.
- miso  input  1  serial data from the slave.

Behaviour:
- Reset (async, active-high) forces these values immediately: ss_n=1, mosi=0, cmd_ready=0, rd_valid=0, rd_data=0, busy=0, state=IDLE, all counters=0.
  - cmd_ready rises in the first cycle after rst deasserts.
- Handshake:
  - A command is accepted on the clk edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready=1 only in IDLE.
  - On acceptance, {cmd_op,cmd_data} is latched into a 10-bit shift register. Input changes after acceptance have no effect.
- State machine: IDLE -> SEL -> SHIFT -> (WAIT -> CAPT, for op 11 only) -> GAP -> IDLE.
- Frame timing, with cycle 0 being the first cycle after acceptance:
  - SEL, cycle 0: ss_n=0, mosi=0.
  - Cycle 1: mosi=op[1], the read/write select bit.
  - SHIFT, cycles 2..11: mosi carries the 10 latched bits, MSB first: op[1], op[0], then data[7..0].
- Ops 00/01/10: ss_n returns to 1 at cycle 12 (ss_n low for exactly 12 cycles). Then GAP holds ss_n=1 for GAP cycles. Then IDLE.
- Op 11:
  - WAIT holds ss_n=0 and mosi=0 for RD_LAT cycles.
  - CAPT samples miso on 8 consecutive edges, MSB first, into a capture register.
  - In the cycle after the 8th sample: rd_data is updated, rd_valid=1 for exactly one cycle, and ss_n=1 (GAP begins).
  - ss_n is low for 12+RD_LAT+8 cycles.
- rd_valid has no backpressure. rd_data holds its value until the next read-data capture completes.
- cmd_valid is ignored while busy. The requester keeps it asserted until the handshake completes.
- busy = (state != IDLE).
- With a back-to-back cmd_valid, the next SEL starts exactly GAP+1 cycles after ss_n rises: GAP gap cycles, plus 1 cycle in IDLE for acceptance.
- Bit counter: 4 bits, counting 0..9 in SHIFT and 0..7 in CAPT. There is no wrap beyond these terminal values. The WAIT counter is sized by clog2(RD_LAT+1).
- RD_LAT=0 is legal: CAPT directly follows SHIFT.
- rst asserted mid-frame: ss_n goes to 1 immediately and no rd_valid pulse is produced. A partial capture is discarded and rd_data returns to 0.

Decomposition:
- Shared package spi_ram_pkg holds:
  - op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - CMD_W=10;
  - the state enum.
- One sub-module, spi_host_shifter: the 10-bit parallel-load MSB-first output shifter plus the DATA_W-bit MSB-first input shifter, with load/shift_out/shift_in enables. The FSM and counters remain in spi_ram_host.

Test Plan:
- Write-addr: op=00, data=0x3C -> ss_n low 12 cycles; mosi sequence 0,0,0,0,0,1,1,1,1,0,0 over cycles 1..11; no rd_valid.
- Write-data then read-back: op=00 data=0x05, op=01 data=0xA7, op=10 data=0x05, op=11 against a slave/RAM model -> one rd_valid pulse with rd_data=0xA7; ss_n low 22 cycles for RD_LAT=2.
- Back-to-back: cmd_valid held high for two op=01 commands -> second SEL begins exactly 2 cycles after ss_n rises (GAP=1); cmd_ready low throughout each frame.
- Ignore-while-busy: toggle cmd_op/cmd_data/cmd_valid mid-frame -> mosi stream unchanged; no extra frame.
- Reset mid-read: assert rst during CAPT bit 4 -> ss_n=1 and rd_data=0 in the same cycle; no rd_valid; cmd_ready=1 in the first cycle after rst deasserts.
- RD_LAT=0 build, miso driven 0x5A MSB-first starting cycle 12 -> rd_data=0x5A, rd_valid at cycle 20.
